// File: rtl/exe_muldiv_unit_pkg.sv
// exe_muldiv_unit_pkg
// Shared definitions for the EXE-stage multiply/divide unit: the datapath
// word length, the EXE command width, the mul/div command encodings, the FSM
// state type, and small command-decode helpers.
// Optional feature macro used by the importing files: MULDIV_SIGNED_EN.
package exe_muldiv_unit_pkg;

    localparam int unsigned WORD_LEN      = 32;
    localparam int unsigned EXE_CMD_LEN   = 4;
    localparam int unsigned MULDIV_OP_LEN = 3;

    localparam logic [MULDIV_OP_LEN-1:0] MULDIV_MULTU = 3'b000;
    localparam logic [MULDIV_OP_LEN-1:0] MULDIV_MULT  = 3'b001;
    localparam logic [MULDIV_OP_LEN-1:0] MULDIV_DIVU  = 3'b010;
    localparam logic [MULDIV_OP_LEN-1:0] MULDIV_DIV   = 3'b011;
    localparam logic [MULDIV_OP_LEN-1:0] MULDIV_MTHI  = 3'b100;
    localparam logic [MULDIV_OP_LEN-1:0] MULDIV_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_t;

    // True for MULTU/MULT/DIVU/DIV, i.e. commands that occupy the iterator.
    function automatic logic op_is_iter(input logic [MULDIV_OP_LEN-1:0] op);
        return (op[2] == 1'b0);
    endfunction

    // True for DIVU/DIV.
    function automatic logic op_is_div(input logic [MULDIV_OP_LEN-1:0] op);
        return (op[2:1] == 2'b01);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix
// Combinational sign correction applied to the magnitude results of the
// multiply/divide iterator. Only instantiated when MULDIV_SIGNED_EN is set.
// Ports:
//   pr       in  2*WIDTH  raw iterator register (product, or {remainder, quotient})
//   neg_res  in  1        negate product / quotient (sa ^ sb)
//   neg_rem  in  1        negate remainder (sa, truncating division)
//   prod     out 2*WIDTH  corrected product
//   quo      out WIDTH    corrected quotient
//   rem      out WIDTH    corrected remainder
module muldiv_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] pr,
    input  logic               neg_res,
    input  logic               neg_rem,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quo,
    output logic [WIDTH-1:0]   rem
);

    always_comb begin
        prod = neg_res ? (~pr + 1'b1) : pr;
        quo  = neg_res ? (~pr[WIDTH-1:0] + 1'b1) : pr[WIDTH-1:0];
        rem  = neg_rem ? (~pr[2*WIDTH-1:WIDTH] + 1'b1) : pr[2*WIDTH-1:WIDTH];
    end

endmodule

// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit
// Multi-cycle radix-2 multiply/divide unit with architectural HI/LO
// registers, sitting in the EXE stage next to the ALU. MULT(U)/DIV(U) take
// WIDTH iteration cycles plus one fix-up cycle; MTHI/MTLO write in one edge.
// Optional feature: MULDIV_SIGNED_EN enables signed MULT/DIV; without it
// MULT behaves as MULTU and DIV as DIVU with identical latency.
// Ports:
//   clk          in  1      clock
//   rst          in  1      synchronous active-high reset
//   start        in  1      command valid (sampled only when idle)
//   flush        in  1      abort in-flight op; blocks a start in the same cycle
//   op           in  3      command (see exe_muldiv_unit_pkg encodings)
//   a            in  WIDTH  operand 1 (rs)
//   b            in  WIDTH  operand 2 (rt)
//   busy         out 1      unit occupied, stall request
//   done         out 1      one-cycle pulse, HI/LO updated by mul/div
//   div_by_zero  out 1      one-cycle pulse with done for divide by zero
//   hi           out WIDTH  HI register
//   lo           out WIDTH  LO register
module exe_muldiv_unit
    import exe_muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_LEN,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     flush,
    input  logic [MULDIV_OP_LEN-1:0] op,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     busy,
    output logic                     done,
    output logic                     div_by_zero,
    output logic [WIDTH-1:0]         hi,
    output logic [WIDTH-1:0]         lo
);

    muldiv_state_t      state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] pr;        // product, or {remainder, quotient}
    logic [WIDTH-1:0]   opb;       // multiplicand / divisor magnitude
    logic               is_div;
    logic               dz_pend;

    // Operand magnitudes and sign bits captured at start.
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

`ifdef MULDIV_SIGNED_EN
    logic               sa;
    logic               sb;
    logic               sa_in;
    logic               sb_in;

    always_comb begin
        sa_in = op_is_iter(op) & op[0] & a[WIDTH-1];
        sb_in = op_is_iter(op) & op[0] & b[WIDTH-1];
        a_mag = sa_in ? (~a + 1'b1) : a;
        b_mag = sb_in ? (~b + 1'b1) : b;
    end
`else
    always_comb begin
        a_mag = a;
        b_mag = b;
    end
`endif

    // One radix-2 step. Multiply: add multiplicand into the upper half when
    // the current multiplier bit is set, then shift right. Divide: shift the
    // {remainder, quotient} pair left and keep the trial subtraction if it
    // did not borrow (restoring division).
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] pr_step;

    always_comb begin
        mul_sum  = {1'b0, pr[2*WIDTH-1:WIDTH]} + (pr[0] ? {1'b0, opb} : '0);
        div_part = pr[2*WIDTH-1:WIDTH-1];
        div_diff = div_part - {1'b0, opb};
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                pr_step = {div_diff[WIDTH-1:0], pr[WIDTH-2:0], 1'b1};
            end else begin
                pr_step = {div_part[WIDTH-1:0], pr[WIDTH-2:0], 1'b0};
            end
        end else begin
            pr_step = {mul_sum, pr[WIDTH-1:1]};
        end
    end

    // Final HI/LO values written in FIX. The register layout already matches
    // {hi, lo} for both multiply and divide, so only signed builds differ.
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

`ifdef MULDIV_SIGNED_EN
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    muldiv_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .pr      (pr),
        .neg_res (sa ^ sb),
        .neg_rem (sa),
        .prod    (prod_fix),
        .quo     (quo_fix),
        .rem     (rem_fix)
    );

    always_comb begin
        res_hi = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        res_lo = is_div ? quo_fix : prod_fix[WIDTH-1:0];
    end
`else
    always_comb begin
        res_hi = pr[2*WIDTH-1:WIDTH];
        res_lo = pr[WIDTH-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pr          <= '0;
            opb         <= '0;
            is_div      <= 1'b0;
            dz_pend     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
`ifdef MULDIV_SIGNED_EN
            sa          <= 1'b0;
            sb          <= 1'b0;
`endif
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        if (op_is_iter(op)) begin
                            is_div <= op_is_div(op);
                            cnt    <= '0;
                            busy   <= 1'b1;
                            if (op_is_div(op) && (b == '0)) begin
                                // Divide by zero skips iteration: preload the
                                // fixed result and let FIX publish it unsigned.
                                pr      <= {a, {WIDTH{1'b1}}};
                                opb     <= '0;
                                dz_pend <= 1'b1;
                                state   <= ST_FIX;
`ifdef MULDIV_SIGNED_EN
                                sa      <= 1'b0;
                                sb      <= 1'b0;
`endif
                            end else begin
                                pr      <= {{WIDTH{1'b0}}, a_mag};
                                opb     <= b_mag;
                                dz_pend <= 1'b0;
                                state   <= ST_RUN;
`ifdef MULDIV_SIGNED_EN
                                sa      <= sa_in;
                                sb      <= sb_in;
`endif
                            end
                        end else if (op == MULDIV_MTHI) begin
                            hi <= a;
                        end else if (op == MULDIV_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        pr <= pr_step;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state <= ST_FIX;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        hi          <= res_hi;
                        lo          <= res_lo;
                        done        <= 1'b1;
                        div_by_zero <= dz_pend;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// tb_exe_muldiv_unit
// Self-checking bench for exe_muldiv_unit: directed cases, flush/reset
// aborts, and randomized commands checked against a plain-arithmetic model.
// Honours MULDIV_SIGNED_EN the same way as the design.
module tb_exe_muldiv_unit;
    import exe_muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    exe_muldiv_unit #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .flush       (flush),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model. kind: 0 = mul/div, 1 = move-to, 2 = no-op.
    task automatic model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                         output int kind, output logic [31:0] eh, output logic [31:0] el,
                         output logic edz, output int ebusy);
        logic [63:0]        p;
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        logic signed [63:0] q;
        logic signed [63:0] r;
        logic               sgn;
`ifdef MULDIV_SIGNED_EN
        sgn = mop[0];
`else
        sgn = 1'b0;
`endif
        kind  = 2;
        eh    = m_hi;
        el    = m_lo;
        edz   = 1'b0;
        ebusy = 33;
        sa64  = $signed({{32{ma[31]}}, ma});
        sb64  = $signed({{32{mb[31]}}, mb});
        if (mop == 3'd0 || mop == 3'd1) begin
            kind = 0;
            if (sgn) p = sa64 * sb64;
            else     p = {32'b0, ma} * {32'b0, mb};
            eh = p[63:32];
            el = p[31:0];
        end else if (mop == 3'd2 || mop == 3'd3) begin
            kind = 0;
            if (mb == 32'd0) begin
                eh    = ma;
                el    = 32'hFFFF_FFFF;
                edz   = 1'b1;
                ebusy = 1;
            end else if (sgn) begin
                q  = sa64 / sb64;
                r  = sa64 % sb64;
                el = q[31:0];
                eh = r[31:0];
            end else begin
                el = ma / mb;
                eh = ma % mb;
            end
        end else if (mop == 3'd4) begin
            kind = 1;
            eh   = ma;
        end else if (mop == 3'd5) begin
            kind = 1;
            el   = ma;
        end
    endtask

    // Called at a negedge; returns at the negedge just after the sampling edge.
    task automatic launch(input logic [2:0] lop, input logic [31:0] la, input logic [31:0] lb);
        op    = lop;
        a     = la;
        b     = lb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] eh, input logic [31:0] el,
                             input logic edz, input int ebusy);
        int busyc = 0;
        bit seen  = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busyc++;
                @(negedge clk);
            end
        end
        check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
        check_eq({tag, "_busy_cycles"}, 64'(busyc), 64'(ebusy));
        check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check_eq({tag, "_hi"}, 64'(hi), 64'(eh));
        check_eq({tag, "_lo"}, 64'(lo), 64'(el));
        check_eq({tag, "_dz"}, 64'(div_by_zero), 64'(edz));
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic do_muldiv(input string tag, input logic [2:0] dop, input logic [31:0] da,
                             input logic [31:0] db, input logic [31:0] eh, input logic [31:0] el,
                             input logic edz, input int ebusy);
        launch(dop, da, db);
        wait_done(tag, eh, el, edz, ebusy);
        @(negedge clk);
        check_eq({tag, "_done_once"}, 64'(done), 64'd0);
    endtask

    task automatic do_move(input string tag, input logic [2:0] dop, input logic [31:0] da,
                           input logic [31:0] eh, input logic [31:0] el);
        launch(dop, da, 32'h0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
        check_eq({tag, "_hi"}, 64'(hi), 64'(eh));
        check_eq({tag, "_lo"}, 64'(lo), 64'(el));
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int seen_done = 0;
        for (int c = 0; c < cycles; c++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        check_eq({tag, "_no_done"}, 64'(seen_done), 64'd0);
    endtask

    initial begin
        int          kind;
        int          ebusy;
        logic [31:0] eh;
        logic [31:0] el;
        logic        edz;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_dz", 64'(div_by_zero), 64'd0);
        check_eq("rst_hi", 64'(hi), 64'd0);
        check_eq("rst_lo", 64'(lo), 64'd0);

        do_muldiv("multu_max", MULDIV_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
`ifdef MULDIV_SIGNED_EN
        do_muldiv("mult_neg", MULDIV_MULT, 32'hFFFF_FFFE, 32'd3,
                  32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 33);
        do_muldiv("div_neg", MULDIV_DIV, 32'hFFFF_FFF9, 32'd2,
                  32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
        do_muldiv("div_ovf", MULDIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                  32'h0000_0000, 32'h8000_0000, 1'b0, 33);
`else
        do_muldiv("mult_neg", MULDIV_MULT, 32'hFFFF_FFFE, 32'd3,
                  32'h0000_0002, 32'hFFFF_FFFA, 1'b0, 33);
        do_muldiv("div_neg", MULDIV_DIV, 32'hFFFF_FFF9, 32'd2,
                  32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 33);
        do_muldiv("div_ovf", MULDIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                  32'h8000_0000, 32'h0000_0000, 1'b0, 33);
`endif
        do_muldiv("divu_100_7", MULDIV_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
        do_muldiv("div_zero", MULDIV_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1);
        do_move("mthi", MULDIV_MTHI, 32'h1234, 32'h1234, m_lo);
        do_move("mtlo", MULDIV_MTLO, 32'h5678, 32'h1234, 32'h5678);

        // Back-to-back: second start issued in the cycle done is high.
        launch(MULDIV_MULTU, 32'd6, 32'd7);
        wait_done("b2b_first", 32'd0, 32'd42, 1'b0, 33);
        launch(MULDIV_DIVU, 32'd50, 32'd8);
        wait_done("b2b_second", 32'd2, 32'd6, 1'b0, 33);
        @(negedge clk);

        // Start while busy is ignored.
        launch(MULDIV_MULTU, 32'd1000, 32'd3);
        op    = MULDIV_MTLO;
        a     = 32'h1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("start_busy", 32'd0, 32'd3000, 1'b0, 32);
        @(negedge clk);

        // Flush in RUN at cycle 10.
        launch(MULDIV_MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_run_busy", 64'(busy), 64'd0);
        watch_no_done("flush_run", 40);
        check_eq("flush_run_hi", 64'(hi), 64'(m_hi));
        check_eq("flush_run_lo", 64'(lo), 64'(m_lo));

        // Flush landing on the FIX cycle.
        launch(MULDIV_DIVU, 32'd99, 32'd4);
        repeat (32) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_fix_busy", 64'(busy), 64'd0);
        check_eq("flush_fix_done", 64'(done), 64'd0);
        check_eq("flush_fix_hi", 64'(hi), 64'(m_hi));
        check_eq("flush_fix_lo", 64'(lo), 64'(m_lo));

        // Flush together with start in IDLE blocks the start.
        op    = MULDIV_MTHI;
        a     = 32'hCAFE_F00D;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check_eq("flush_start_hi", 64'(hi), 64'(m_hi));
        check_eq("flush_start_busy", 64'(busy), 64'd0);

        // Reset mid-operation.
        launch(MULDIV_MULTU, 32'hFFFF_0000, 32'h0000_FFFF);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_mid_busy", 64'(busy), 64'd0);
        check_eq("rst_mid_hi", 64'(hi), 64'd0);
        check_eq("rst_mid_lo", 64'(lo), 64'd0);
        m_hi = '0;
        m_lo = '0;
        watch_no_done("rst_mid", 40);

        // Randomized commands against the model.
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            model(rop, ra, rb, kind, eh, el, edz, ebusy);
            if (kind == 0) begin
                do_muldiv($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, eh, el, edz, ebusy);
            end else begin
                do_move($sformatf("rnd%0d_op%0d", i, rop), rop, ra, eh, el);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
